z80_io_cycle_master: RTL and testbench

Bus-master engine that turns a simple request/acknowledge transaction into a cycle-accurate Z80 I/O read or write cycle on the Z80-style peripheral bus. It drives address, data, IORQ_n, RD_n and WR_n, and honours the WAIT_n line produced by the I/O-side wait-state generator. It sits between an internal initiator (DMA engine, debug port, bridge) and the Z80 I/O bus, so the initiator sees the same cycle timing and wait behaviour as a real Z80.

---
 rtl/z80_io_cycle_master_pkg.sv | 25 ++
 rtl/z80_wait_timer.sv | 35 +++
 rtl/z80_io_cycle_master.sv | 132 +++++++++++++
 tb/tb_z80_io_cycle_master.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80_io_cycle_master_pkg.sv
// rtl/z80_io_cycle_master_pkg.sv - shared Z80 bus definitions: state encoding, strobe levels, T-state counts
`ifndef Z80_BUS_DEFS_SV
`define Z80_BUS_DEFS_SV

package z80_io_cycle_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_TWA  = 3'd3,
      ST_TW   = 3'd4,
      ST_T3   = 3'd5
   } io_state_t;

   localparam logic STROBE_IDLE   = 1'b1;
   localparam logic STROBE_ACTIVE = 1'b0;

   // Minimum bus-cycle lengths, shared with the memory and M1 masters.
   localparam int TSTATES_IO_MIN  = 4;
   localparam int TSTATES_MEM_MIN = 3;

endpackage

`endif

// File: rtl/z80_wait_timer.sv
// rtl/z80_wait_timer.sv - TW-state counter with MAX_WAIT compare and sticky timeout flag
module z80_wait_timer #(
   parameter int MAX_WAIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   input  logic expire,
   output logic at_max,
   output logic timed_out
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_WAIT);
   localparam logic [CW-1:0] CNT_SAT   = '1;

   logic [CW-1:0] count;

   // Saturates rather than wrapping so an unbounded wait never aliases to a small count.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count     <= '0;
         timed_out <= 1'b0;
      end else begin
         if (inc && (count != CNT_SAT))
            count <= count + CW'(1);
         if (expire)
            timed_out <= 1'b1;
      end
   end

   assign at_max = (MAX_WAIT != 0) && (count == CNT_LIMIT);

endmodule

// File: rtl/z80_io_cycle_master.sv
// rtl/z80_io_cycle_master.sv - Z80 I/O read/write bus-cycle master with WAIT_n and wait timeout
// Optional auto wait state (TWA) after T2 when Z80_IO_MASTER_AUTO_WAIT_EN is defined.
module z80_io_cycle_master
   import z80_io_cycle_master_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_wdata,
   output logic        o_ready,
   output logic        o_ack,
   output logic        o_timeout,
   output logic [7:0]  o_rdata,
   output logic [15:0] o_addr,
   output logic [7:0]  o_data,
   output logic        o_data_oe,
   input  logic [7:0]  i_data,
   output logic        o_iorq_n,
   output logic        o_rd_n,
   output logic        o_wr_n,
   input  logic        i_wait_n
);

   io_state_t state, state_next;
   logic      we_q;
   logic      accept;
   logic      we_next;
   logic      strobe_on;
   logic      oe_next;
   logic      iorq_n_next, rd_n_next, wr_n_next;
   logic      tmr_clear, tmr_inc, tmr_expire, tmr_at_max, tmr_flag;

   z80_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk       (i_clk),
      .reset     (i_reset),
      .clear     (tmr_clear),
      .inc       (tmr_inc),
      .expire    (tmr_expire),
      .at_max    (tmr_at_max),
      .timed_out (tmr_flag)
   );

   assign o_ready = (state == ST_IDLE);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      tmr_clear  = 1'b0;
      tmr_inc    = 1'b0;
      tmr_expire = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_req) begin
               state_next = ST_T1;
               accept     = 1'b1;
               tmr_clear  = 1'b1;
            end
         end
         ST_T1: state_next = ST_T2;
`ifdef Z80_IO_MASTER_AUTO_WAIT_EN
         ST_T2: state_next = ST_TWA;
         ST_TWA: begin
`else
         ST_T2, ST_TWA: begin
`endif
            if (!i_wait_n) begin
               state_next = ST_TW;
               tmr_inc    = 1'b1;
            end else begin
               state_next = ST_T3;
            end
         end
         ST_TW: begin
            if (i_wait_n) begin
               state_next = ST_T3;
            end else if (tmr_at_max) begin
               state_next = ST_T3;
               tmr_expire = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_T3:   state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      // Bus levels are computed for the state being entered so they can be registered.
      we_next     = accept ? i_we : we_q;
      strobe_on   = (state_next == ST_T2) || (state_next == ST_TWA) ||
                    (state_next == ST_TW) || (state_next == ST_T3);
      oe_next     = (state_next != ST_IDLE) && we_next;
      iorq_n_next = strobe_on ? STROBE_ACTIVE : STROBE_IDLE;
      rd_n_next   = (strobe_on && !we_next) ? STROBE_ACTIVE : STROBE_IDLE;
      wr_n_next   = (strobe_on && we_next) ? STROBE_ACTIVE : STROBE_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         we_q      <= 1'b0;
         o_addr    <= '0;
         o_data    <= '0;
         o_data_oe <= 1'b0;
         o_iorq_n  <= STROBE_IDLE;
         o_rd_n    <= STROBE_IDLE;
         o_wr_n    <= STROBE_IDLE;
         o_ack     <= 1'b0;
         o_timeout <= 1'b0;
         o_rdata   <= '0;
      end else begin
         state     <= state_next;
         if (accept) begin
            we_q   <= i_we;
            o_addr <= i_addr;
            o_data <= i_wdata;
         end
         o_data_oe <= oe_next;
         o_iorq_n  <= iorq_n_next;
         o_rd_n    <= rd_n_next;
         o_wr_n    <= wr_n_next;
         o_ack     <= (state == ST_T3);
         o_timeout <= (state == ST_T3) && tmr_flag;
         if ((state == ST_T3) && !we_q)
            o_rdata <= i_data;
      end
   end

endmodule

// File: tb/tb_z80_io_cycle_master.sv
// tb/tb_z80_io_cycle_master.sv - randomized bench with transaction-level timeline model of the I/O master
module tb_z80_io_cycle_master;

   localparam int MAXW = 3;
   localparam int NCYC = 2000;
`ifdef Z80_IO_MASTER_AUTO_WAIT_EN
   localparam int AUTO = 1;
`else
   localparam int AUTO = 0;
`endif
   localparam int LIT_A0 = AUTO ? 5 : 4;
   localparam int LIT_A1 = AUTO ? 10 : 8;
   localparam int LIT_A2 = AUTO ? 18 : 15;

   logic        clk = 1'b0;
   logic        i_reset, i_req, i_we, i_wait_n;
   logic [15:0] i_addr;
   logic [7:0]  i_wdata, i_data;
   logic        o_ready, o_ack, o_timeout, o_data_oe, o_iorq_n, o_rd_n, o_wr_n;
   logic [7:0]  o_rdata, o_data;
   logic [15:0] o_addr;

   always #5 clk = ~clk;

   z80_io_cycle_master #(.MAX_WAIT(MAXW)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
      .i_wdata(i_wdata), .o_ready(o_ready), .o_ack(o_ack), .o_timeout(o_timeout),
      .o_rdata(o_rdata), .o_addr(o_addr), .o_data(o_data), .o_data_oe(o_data_oe),
      .i_data(i_data), .o_iorq_n(o_iorq_n), .o_rd_n(o_rd_n), .o_wr_n(o_wr_n),
      .i_wait_n(i_wait_n)
   );

   // Per-cycle stimulus schedule
   logic        req_s [NCYC];
   logic        we_s  [NCYC];
   logic [15:0] addr_s [NCYC];
   logic [7:0]  wdata_s [NCYC];
   logic [7:0]  data_s [NCYC];
   logic        wait_s [NCYC];
   // Per-cycle expected outputs
   logic        e_ready [NCYC], e_ack [NCYC], e_to [NCYC], e_oe [NCYC];
   logic        e_iorq [NCYC], e_rd [NCYC], e_wr [NCYC];
   logic [15:0] e_addr [NCYC];
   logic [7:0]  e_data [NCYC], e_rdata [NCYC];
   logic        set_a [NCYC], set_r [NCYC];
   logic [15:0] set_addr_v [NCYC];
   logic [7:0]  set_data_v [NCYC], set_r_v [NCYC];

   int cyc = -1;
   bit running = 1'b0;
   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Each transaction is a timeline: accept at t, T1 at t+1, WAIT_n first sampled at S,
   // min(n, MAXW) TW states when WAIT_n is held low for n samples, T3, then ack.
   task automatic plan();
      int t, k, s, n, tw, a, gap;
      logic we;
      logic [15:0] addr;
      logic [7:0] wdata;
      logic to;
      logic [15:0] av;
      logic [7:0] dv, rv;
      for (int c = 0; c < NCYC; c++) begin
         req_s[c] = 1'b0; we_s[c] = 1'($urandom); addr_s[c] = 16'($urandom);
         wdata_s[c] = 8'($urandom); data_s[c] = 8'($urandom); wait_s[c] = 1'b1;
         e_ready[c] = 1'b1; e_ack[c] = 1'b0; e_to[c] = 1'b0; e_oe[c] = 1'b0;
         e_iorq[c] = 1'b1; e_rd[c] = 1'b1; e_wr[c] = 1'b1;
         set_a[c] = 1'b0; set_r[c] = 1'b0; set_addr_v[c] = '0; set_data_v[c] = '0; set_r_v[c] = '0;
      end
      t = 0;
      k = 0;
      while (t + 60 < NCYC) begin
         we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
         n = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, MAXW + 2));
         gap = int'($urandom_range(0, 3));
         case (k)
            0: begin we = 1'b1; addr = 16'h00F1; wdata = 8'h5A; n = 0; gap = 0; end
            1: begin we = 1'b0; addr = 16'h1234; n = 0; gap = 1; end
            2: begin we = 1'b0; n = 2; gap = 2; end
            3: begin we = 1'b0; n = MAXW + 5; gap = 0; end
            4: begin we = 1'b1; n = MAXW; gap = 1; end
            5: begin we = 1'b0; n = MAXW + 1; gap = 0; end
            default: ;
         endcase
         s  = t + 2 + AUTO;
         tw = (n < MAXW) ? n : MAXW;
         to = (n > MAXW);
         a  = s + tw + 2;
         req_s[t] = 1'b1; we_s[t] = we; addr_s[t] = addr; wdata_s[t] = wdata;
         for (int c = t + 1; c < a; c++) begin
            req_s[c] = 1'($urandom);
            e_ready[c] = 1'b0;
            e_oe[c] = we;
         end
         for (int c = t + 2; c < a; c++) begin
            e_iorq[c] = 1'b0; e_rd[c] = we; e_wr[c] = !we;
         end
         for (int c = t + 1; c < s; c++) wait_s[c] = 1'($urandom);
         for (int c = s; c < s + n && c < a; c++) wait_s[c] = 1'b0;
         e_ack[a] = 1'b1;
         e_to[a] = to;
         set_a[t + 1] = 1'b1; set_addr_v[t + 1] = addr; set_data_v[t + 1] = wdata;
         if (k == 1) data_s[a - 1] = 8'hC3;
         if (!we) begin
            set_r[a] = 1'b1;
            set_r_v[a] = data_s[a - 1];
         end
         for (int c = a; c < a + gap; c++) begin
            req_s[c] = 1'b0;
            wait_s[c] = 1'($urandom);
         end
         t = a + gap;
         k++;
      end
      av = '0; dv = '0; rv = '0;
      for (int c = 0; c < NCYC; c++) begin
         if (set_a[c]) begin av = set_addr_v[c]; dv = set_data_v[c]; end
         if (set_r[c]) rv = set_r_v[c];
         e_addr[c] = av; e_data[c] = dv; e_rdata[c] = rv;
      end
   endtask

   task automatic drive(input int c);
      i_req = req_s[c]; i_we = we_s[c]; i_addr = addr_s[c];
      i_wdata = wdata_s[c]; i_data = data_s[c]; i_wait_n = wait_s[c];
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (running && cyc >= 0 && cyc < NCYC) begin
            check("ready", o_ready, e_ready[cyc]);
            check("ack", o_ack, e_ack[cyc]);
            if (e_ack[cyc]) check("timeout", o_timeout, e_to[cyc]);
            check("iorq_n", o_iorq_n, e_iorq[cyc]);
            check("rd_n", o_rd_n, e_rd[cyc]);
            check("wr_n", o_wr_n, e_wr[cyc]);
            check("data_oe", o_data_oe, e_oe[cyc]);
            check("addr", o_addr, e_addr[cyc]);
            check("data", o_data, e_data[cyc]);
            check("rdata", o_rdata, e_rdata[cyc]);
            if (cyc == 0) begin
               check("lit_reset_ready", o_ready, 1'b1);
               check("lit_reset_rdata", o_rdata, 8'h00);
            end
            if (cyc >= 2 && cyc <= 3 + AUTO) begin
               check("lit_w0_iorq_n", o_iorq_n, 1'b0);
               check("lit_w0_wr_n", o_wr_n, 1'b0);
               check("lit_w0_data", o_data, 8'h5A);
               check("lit_w0_oe", o_data_oe, 1'b1);
            end
            if (cyc == LIT_A0) begin
               check("lit_w0_ack", o_ack, 1'b1);
               check("lit_w0_timeout", o_timeout, 1'b0);
            end
            if (cyc == LIT_A1) begin
               check("lit_r1_ack", o_ack, 1'b1);
               check("lit_r1_rdata", o_rdata, 8'hC3);
            end
            if (cyc == LIT_A2 - 1) begin
               check("lit_r2_noack", o_ack, 1'b0);
               check("lit_r2_rd_n", o_rd_n, 1'b0);
            end
            if (cyc == LIT_A2) check("lit_r2_ack", o_ack, 1'b1);
         end
      end
   end

   initial begin
      plan();
      i_reset = 1'b1;
      drive(0);
      i_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      i_reset = 1'b0;
      cyc = 0;
      running = 1'b1;
      drive(0);
      for (int c = 1; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         drive(c);
      end
      @(posedge clk);
      #1;
      cyc = NCYC;
      running = 1'b0;
      // Reset in the middle of a stretched read
      i_req = 1'b1; i_we = 1'b0; i_addr = 16'hBEEF; i_wait_n = 1'b0; i_data = 8'hA5;
      @(posedge clk);
      #1;
      i_req = 1'b0;
      repeat (2 + AUTO) @(posedge clk);
      @(negedge clk);
      check("rst_pre_rd_n", o_rd_n, 1'b0);
      check("rst_pre_iorq_n", o_iorq_n, 1'b0);
      i_reset = 1'b1;
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      @(negedge clk);
      check("rst_iorq_n", o_iorq_n, 1'b1);
      check("rst_rd_n", o_rd_n, 1'b1);
      check("rst_wr_n", o_wr_n, 1'b1);
      check("rst_ready", o_ready, 1'b1);
      check("rst_ack", o_ack, 1'b0);
      check("rst_rdata", o_rdata, 8'h00);
      check("rst_oe", o_data_oe, 1'b0);
      repeat (6) begin
         @(negedge clk);
         check("rst_post_ack", o_ack, 1'b0);
         check("rst_post_ready", o_ready, 1'b1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
